// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line levels and divider limits.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam int UART_DEFAULT_DIV = 625;
  localparam int UART_MIN_DIV     = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs; the reset value is
// chosen per use so an idle line does not look like an edge coming out of reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 receive front end: synchronise, find the start bit, sample at mid-bit, frame bytes.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each mid-bit point.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int DIV_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_bit,
  input  logic [DIV_W-1:0] freq_divider,
  input  logic             fifo_full,
  output logic [7:0]       rx_data,
  output logic             rx_push,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ_DELAY = 1;
  localparam int MIN_HALF  = 3;
`else
  localparam int MAJ_DELAY = 0;
  localparam int MIN_HALF  = UART_MIN_DIV;
`endif

  localparam logic [DIV_W:0]   ONE       = (DIV_W+1)'(1);
  localparam logic [DIV_W:0]   START_OFS = (DIV_W+1)'(MAJ_DELAY);
  localparam logic [DIV_W-1:0] HALF_MIN  = DIV_W'(MIN_HALF);

  rx_state_t        state, state_next;
  logic             rxs, rxs_prev, fall;
  logic [DIV_W-1:0] half, div_clamped;
  logic [DIV_W:0]   cnt, cnt_end;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             at_end, bit_val;
  logic             push_d, ferr_d, ovr_d;

  uart_sync2 #(.RESET_VAL(HIGH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_bit),
    .q     (rxs)
  );

  assign fall        = rxs_prev & ~rxs;
  assign div_clamped = (freq_divider < HALF_MIN) ? HALF_MIN : freq_divider;

  // START ends at mid start bit; later states count whole bit periods from the
  // previous decision, so the majority delay is paid once and never accumulates.
  assign cnt_end = (state == RX_START) ? ({1'b0, half} - ONE + START_OFS)
                                       : ({half, 1'b0} - ONE);
  assign at_end  = (cnt == cnt_end);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // hist holds rxs from the two cycles before the decision cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hist <= {HIGH, HIGH};
    else        hist <= {hist[0], rxs};
  end

  assign bit_val = maj3(hist[1], hist[0], rxs);
`else
  assign bit_val = rxs;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RX_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    push_d     = LOW;
    ferr_d     = LOW;
    ovr_d      = LOW;
    unique case (state)
      RX_IDLE:  if (fall) state_next = RX_START;
      RX_START: if (at_end) state_next = bit_val ? RX_IDLE : RX_DATA;
      RX_DATA:  if (at_end && idx == 3'd7) state_next = RX_STOP;
      RX_STOP: begin
        if (at_end) begin
          if (bit_val) begin
            state_next = RX_IDLE;
            if (fifo_full) ovr_d  = HIGH;
            else           push_d = HIGH;
          end else begin
            state_next = RX_BREAK;
            ferr_d     = HIGH;
          end
        end
      end
      RX_BREAK: if (rxs) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxs_prev  <= HIGH;
      half      <= HALF_MIN;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_push   <= LOW;
      frame_err <= LOW;
      overrun   <= LOW;
    end else begin
      rxs_prev  <= rxs;
      rx_push   <= push_d;
      frame_err <= ferr_d;
      overrun   <= ovr_d;
      cnt       <= (state == RX_IDLE || at_end) ? '0 : cnt + ONE;
      if (state == RX_IDLE && fall) begin
        half <= div_clamped;
        idx  <= '0;
      end
      if (state == RX_DATA && at_end) begin
        shreg[idx] <= bit_val;
        idx        <= idx + 3'd1;
      end
      if (push_d) rx_data <= shreg;
    end
  end

  assign busy = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: stimulus queues expected pulses, a monitor checks them.
module tb_uart_rx_sampler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_bit = 1'b1;
  logic [9:0] freq_divider = 10'd4;
  logic       fifo_full = 1'b0;
  logic [7:0] rx_data;
  logic       rx_push, frame_err, overrun, busy;

  uart_rx_sampler #(.DIV_W(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_bit       (rx_bit),
    .freq_divider (freq_divider),
    .fifo_full    (fifo_full),
    .rx_data      (rx_data),
    .rx_push      (rx_push),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum logic [1:0] {EV_PUSH, EV_FERR, EV_OVR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    bit         chk_lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   t_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [7:0] d, input bit lat);
    exp_t e;
    e.kind    = k;
    e.data    = d;
    e.chk_lat = lat;
    sb.push_back(e);
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && (rx_push || frame_err || overrun)) begin
      exp_t     e;
      ev_kind_t act;
      int       lat;
      check("pulse_onehot", 32'(rx_push) + 32'(frame_err) + 32'(overrun), 32'd1);
      act = rx_push ? EV_PUSH : (frame_err ? EV_FERR : EV_OVR);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got kind %0d data 0x%0h, expected none", act, rx_data);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", 32'(act), 32'(e.kind));
        check("pulse_data", 32'(rx_data), 32'(e.data));
        if (e.chk_lat) begin
          lat = cyc - t_start;
          checks++;
          if (lat < 76 || lat > 80) begin
            errors++;
            $display("FAIL push_latency: got %0d clocks, expected 76..80", lat);
          end
        end
      end
    end
  end

  task automatic send_bit(input logic v);
    rx_bit = v;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_pulses", {29'd0, rx_push, frame_err, overrun}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Clean 0xA5 with latency measured from the rx_bit falling edge.
    expect_ev(EV_PUSH, 8'hA5, 1'b1);
    t_start = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    check("a5_drained", 32'(sb.size()), 32'd0);

    // Three-clock low glitch: a false start that must return to IDLE silently.
    rx_bit = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_busy_high", 32'(busy), 32'd1);
    rx_bit = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_busy_low", 32'(busy), 32'd0);

    // Overrun: FIFO full at the stop sample, rx_data keeps the previous byte.
    fifo_full = 1'b1;
    expect_ev(EV_OVR, 8'hA5, 1'b0);
    send_frame(8'hFF, 1'b1);
    repeat (10) @(negedge clk);
    fifo_full = 1'b0;
    check("ovr_rx_data_kept", 32'(rx_data), 32'hA5);
    check("ovr_drained", 32'(sb.size()), 32'd0);

    // Framing error followed by a held-low line, then recovery with 0x55.
    expect_ev(EV_FERR, 8'hA5, 1'b0);
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    check("break_busy", 32'(busy), 32'd1);
    rx_bit = 1'b1;
    repeat (16) @(negedge clk);
    check("break_exit_idle", 32'(busy), 32'd0);
    expect_ev(EV_PUSH, 8'h55, 1'b0);
    send_frame(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    check("ferr_55_drained", 32'(sb.size()), 32'd0);

    // Back-to-back frames with no idle gap.
    expect_ev(EV_PUSH, 8'h01, 1'b0);
    expect_ev(EV_PUSH, 8'h80, 1'b0);
    send_frame(8'h01, 1'b1);
    send_frame(8'h80, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_drained", 32'(sb.size()), 32'd0);
    check("b2b_last_data", 32'(rx_data), 32'h80);

    // Asynchronous reset in the middle of DATA, then a clean 0x7E.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("mid_frame_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_rx_data", 32'(rx_data), 32'h00);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_pulses", {29'd0, rx_push, frame_err, overrun}, 32'd0);
    rx_bit = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    expect_ev(EV_PUSH, 8'h7E, 1'b0);
    send_frame(8'h7E, 1'b1);
    repeat (20) @(negedge clk);

    check("all_expected_seen", 32'(sb.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
